// File: rtl/game_pkg.sv
// Shared types and constants for the prediction interface (bbox_extractor, GameLogic).
package game_pkg;

  localparam int unsigned COORD_W     = 11;
  localparam int unsigned NUM_TARGETS = 2;
  localparam int unsigned CNT_W       = 20;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [2:0][7:0]    rgb_t;

  typedef struct packed {
    coord_t left;
    coord_t right;
    coord_t up;
    coord_t down;
  } bbox_t;

  localparam coord_t COORD_MAX = 11'h7FF;
  localparam coord_t H_ACTIVE  = 11'd640;
  localparam coord_t V_ACTIVE  = 11'd480;

  localparam logic [7:0] C_MIN  = 8'd128;
  localparam logic [7:0] MARGIN = 8'd48;

  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] MIN_PIXELS = 20'd64;

  // Empty box: min trackers at the top of the range, max trackers at zero.
  localparam bbox_t BBOX_INIT = '{left: COORD_MAX, right: 11'd0, up: COORD_MAX, down: 11'd0};

  // Dominance test in 9 bits so other+MARGIN cannot wrap.
  function automatic logic dominant(input logic [7:0] d, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] d9;
    d9 = 9'(d);
    return (d >= C_MIN) && (d9 > (9'(a) + 9'(MARGIN))) && (d9 > (9'(b) + 9'(MARGIN)));
  endfunction

endpackage

// File: rtl/bbox_extractor_classifier.sv
// Combinational marker classifier.
//   pix_valid, x, y, rgb : incoming pixel
//   hit_c[0]             : red-dominant in-range pixel
//   hit_c[1]             : blue-dominant in-range pixel
module pixel_classifier
  import game_pkg::*;
(
  input  logic                   pix_valid,
  input  logic [COORD_W-1:0]     x,
  input  logic [COORD_W-1:0]     y,
  input  logic [2:0][7:0]        rgb,
  output logic [NUM_TARGETS-1:0] hit_c
);

  logic in_range;

  always_comb begin
    in_range = pix_valid && (x < H_ACTIVE) && (y < V_ACTIVE);
    hit_c[0] = in_range && dominant(rgb[0], rgb[1], rgb[2]);
    hit_c[1] = in_range && dominant(rgb[2], rgb[0], rgb[1]);
  end

endmodule

// File: rtl/bbox_extractor.sv
// Per-frame bounding-box extractor for the red (0) and blue (1) markers.
//   i_clk, i_rst_n                 : clock, async active-low reset
//   i_pix_valid, i_x, i_y, i_rgb   : pixel stream
//   i_frame_end                    : last cycle of a frame
//   o_left/o_right/o_up/o_down     : published per-target box
//   o_found                        : per-target found flag of last frame
//   o_predict_valid                : one-cycle publish pulse
module bbox_extractor
  import game_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_pix_valid,
  input  logic [10:0]      i_x,
  input  logic [10:0]      i_y,
  input  logic [2:0][7:0]  i_rgb,
  input  logic             i_frame_end,
  output logic [1:0][10:0] o_left,
  output logic [1:0][10:0] o_right,
  output logic [1:0][10:0] o_up,
  output logic [1:0][10:0] o_down,
  output logic [1:0]       o_found,
  output logic             o_predict_valid
);

  logic [NUM_TARGETS-1:0] hit_c;

  logic [NUM_TARGETS-1:0] s1_hit;
  coord_t                 s1_x;
  coord_t                 s1_y;
  logic                   s1_fe;

  bbox_t      [NUM_TARGETS-1:0] acc_box;
  logic [NUM_TARGETS-1:0][CNT_W-1:0] acc_cnt;

  bbox_t      [NUM_TARGETS-1:0] merged_box_c;
  logic [NUM_TARGETS-1:0][CNT_W-1:0] merged_cnt_c;
  logic [NUM_TARGETS-1:0]       found_c;

  pixel_classifier u_classifier (
    .pix_valid (i_pix_valid),
    .x         (i_x),
    .y         (i_y),
    .rgb       (i_rgb),
    .hit_c     (hit_c)
  );

  // Accumulators plus the pixel currently in stage 2.
  always_comb begin
    merged_box_c = acc_box;
    merged_cnt_c = acc_cnt;
    found_c      = '0;
    for (int t = 0; t < NUM_TARGETS; t++) begin
      if (s1_hit[t]) begin
        if (s1_x < acc_box[t].left)  merged_box_c[t].left  = s1_x;
        if (s1_x > acc_box[t].right) merged_box_c[t].right = s1_x;
        if (s1_y < acc_box[t].up)    merged_box_c[t].up    = s1_y;
        if (s1_y > acc_box[t].down)  merged_box_c[t].down  = s1_y;
        if (acc_cnt[t] != CNT_MAX)   merged_cnt_c[t]       = acc_cnt[t] + CNT_W'(1);
      end
      found_c[t] = (merged_cnt_c[t] >= MIN_PIXELS);
    end
  end

  // Stage-1 register, accumulators and published outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_hit          <= '0;
      s1_x            <= '0;
      s1_y            <= '0;
      s1_fe           <= 1'b0;
      acc_box         <= {NUM_TARGETS{BBOX_INIT}};
      acc_cnt         <= '0;
      o_left          <= '0;
      o_right         <= '0;
      o_up            <= '0;
      o_down          <= '0;
      o_found         <= '0;
      o_predict_valid <= 1'b0;
    end else begin
      s1_hit          <= hit_c;
      s1_x            <= i_x;
      s1_y            <= i_y;
      s1_fe           <= i_frame_end;
      o_predict_valid <= s1_fe;
      if (s1_fe) begin
        o_found <= found_c;
        for (int t = 0; t < NUM_TARGETS; t++) begin
          // A lost target keeps its last known box.
          if (found_c[t]) begin
            o_left[t]  <= merged_box_c[t].left;
            o_right[t] <= merged_box_c[t].right;
            o_up[t]    <= merged_box_c[t].up;
            o_down[t]  <= merged_box_c[t].down;
          end
        end
        acc_box <= {NUM_TARGETS{BBOX_INIT}};
        acc_cnt <= '0;
      end else begin
        acc_box <= merged_box_c;
        acc_cnt <= merged_cnt_c;
      end
    end
  end

endmodule

// File: tb/tb_bbox_extractor.sv
// Directed self-checking bench for bbox_extractor.
module tb_bbox_extractor;

  logic             i_clk;
  logic             i_rst_n;
  logic             i_pix_valid;
  logic [10:0]      i_x;
  logic [10:0]      i_y;
  logic [2:0][7:0]  i_rgb;
  logic             i_frame_end;
  logic [1:0][10:0] o_left;
  logic [1:0][10:0] o_right;
  logic [1:0][10:0] o_up;
  logic [1:0][10:0] o_down;
  logic [1:0]       o_found;
  logic             o_predict_valid;

  int vectors    = 0;
  int miscompares = 0;
  int pulses;

  bbox_extractor dut (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .i_pix_valid     (i_pix_valid),
    .i_x             (i_x),
    .i_y             (i_y),
    .i_rgb           (i_rgb),
    .i_frame_end     (i_frame_end),
    .o_left          (o_left),
    .o_right         (o_right),
    .o_up            (o_up),
    .o_down          (o_down),
    .o_found         (o_found),
    .o_predict_valid (o_predict_valid)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_box(input string tag, input int t, input int l, input int r, input int u, input int d);
    chk({tag, ".left"},  32'(o_left[t]),  32'(l));
    chk({tag, ".right"}, 32'(o_right[t]), 32'(r));
    chk({tag, ".up"},    32'(o_up[t]),    32'(u));
    chk({tag, ".down"},  32'(o_down[t]),  32'(d));
  endtask

  // Present one cycle of input, return 1 time unit after the capturing edge.
  task automatic pix(input int x, input int y, input logic [7:0] r, input logic [7:0] g,
                     input logic [7:0] b, input logic vld, input logic fe);
    i_pix_valid = vld;
    i_x         = 11'(x);
    i_y         = 11'(y);
    i_rgb[0]    = r;
    i_rgb[1]    = g;
    i_rgb[2]    = b;
    i_frame_end = fe;
    @(posedge i_clk);
    #1;
    i_pix_valid = 1'b0;
    i_frame_end = 1'b0;
  endtask

  task automatic red(input int x, input int y);
    pix(x, y, 8'd255, 8'd0, 8'd0, 1'b1, 1'b0);
  endtask

  task automatic blue(input int x, input int y);
    pix(x, y, 8'd0, 8'd0, 8'd255, 1'b1, 1'b0);
  endtask

  // Idle frame_end, then checks pulse timing; returns with outputs visible.
  task automatic close_frame(input string tag);
    pix(0, 0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b1);
    chk({tag, ".pv_t1"}, 32'(o_predict_valid), 32'd0);
    @(posedge i_clk);
    #1;
    chk({tag, ".pv_t2"}, 32'(o_predict_valid), 32'd1);
  endtask

  task automatic pulse_gone(input string tag);
    @(posedge i_clk);
    #1;
    chk({tag, ".pv_t3"}, 32'(o_predict_valid), 32'd0);
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_pix_valid = 1'b0;
    i_x = '0;
    i_y = '0;
    i_rgb = '0;
    i_frame_end = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    chk("reset.found", 32'(o_found), 32'd0);
    chk("reset.pv", 32'(o_predict_valid), 32'd0);
    chk_box("reset.t0", 0, 0, 0, 0, 0);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;

    // Frame 1: red box corners plus 62 interior pixels.
    red(100, 50);
    red(200, 150);
    for (int i = 0; i < 62; i++) red(101 + i, 60);
    close_frame("f1");
    chk("f1.found", 32'(o_found), 32'd1);
    chk_box("f1.t0", 0, 100, 200, 50, 150);
    chk_box("f1.t1", 1, 0, 0, 0, 0);
    pulse_gone("f1");

    // Frame 2: both targets.
    for (int i = 0; i < 64; i++) begin
      red(10 + (i % 11), 10 + ((i * 3) % 11));
      blue(300 + (i % 11), 400 + ((i * 3) % 11));
    end
    close_frame("f2");
    chk("f2.found", 32'(o_found), 32'd3);
    chk_box("f2.t0", 0, 10, 20, 10, 20);
    chk_box("f2.t1", 1, 300, 310, 400, 410);
    pulse_gone("f2");

    // Frame 3: one short of the threshold, boxes held.
    for (int i = 0; i < 63; i++) red(500, 300);
    close_frame("f3");
    chk("f3.found", 32'(o_found), 32'd0);
    chk_box("f3.t0", 0, 10, 20, 10, 20);
    chk_box("f3.t1", 1, 300, 310, 400, 410);
    pulse_gone("f3");

    // Frame 4: 64th hit rides with frame_end; x=1 in the next cycle is next frame.
    for (int i = 0; i < 63; i++) red(30 + i, 30);
    pix(5, 40, 8'd255, 8'd0, 8'd0, 1'b1, 1'b1);
    chk("f4.pv_t1", 32'(o_predict_valid), 32'd0);
    red(1, 40);
    chk("f4.pv_t2", 32'(o_predict_valid), 32'd1);
    chk("f4.found", 32'(o_found), 32'd1);
    chk_box("f4.t0", 0, 5, 92, 30, 40);
    chk_box("f4.t1", 1, 300, 310, 400, 410);
    for (int i = 0; i < 63; i++) red(50, 50);
    close_frame("f5");
    chk("f5.found", 32'(o_found), 32'd1);
    chk_box("f5.t0", 0, 1, 50, 40, 50);
    pulse_gone("f5");

    // Frame 6: 63 hits plus rejected pixels (range, threshold, margin).
    for (int i = 0; i < 63; i++) red(60, 60);
    red(700, 60);
    red(60, 480);
    pix(61, 61, 8'd127, 8'd0, 8'd0, 1'b1, 1'b0);
    pix(62, 62, 8'd200, 8'd160, 8'd0, 1'b1, 1'b0);
    pix(63, 63, 8'd128, 8'd80, 8'd0, 1'b1, 1'b0);
    pix(64, 64, 8'd255, 8'd0, 8'd0, 1'b0, 1'b0);
    close_frame("f6");
    chk("f6.found", 32'(o_found), 32'd0);
    chk_box("f6.t0", 0, 1, 50, 40, 50);
    pulse_gone("f6");

    // Frame 7: edge-of-range pixel at the exact thresholds is accepted.
    for (int i = 0; i < 63; i++) red(100, 100);
    pix(639, 479, 8'd128, 8'd79, 8'd79, 1'b1, 1'b0);
    close_frame("f7");
    chk("f7.found", 32'(o_found), 32'd1);
    chk_box("f7.t0", 0, 100, 639, 100, 479);
    pulse_gone("f7");

    // Back-to-back empty frames: two pulses, boxes held.
    pix(0, 0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b1);
    pix(0, 0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b1);
    chk("b2b.pv_a", 32'(o_predict_valid), 32'd1);
    @(posedge i_clk);
    #1;
    chk("b2b.pv_b", 32'(o_predict_valid), 32'd1);
    chk("b2b.found", 32'(o_found), 32'd0);
    chk_box("b2b.t0", 0, 100, 639, 100, 479);
    pulse_gone("b2b");

    // Reset mid-frame discards the partial frame.
    pulses = 0;
    for (int i = 0; i < 64; i++) red(7, 7);
    i_rst_n = 1'b0;
    @(posedge i_clk);
    #1;
    pulses += int'(o_predict_valid);
    chk_box("rst.t0", 0, 0, 0, 0, 0);
    @(posedge i_clk);
    #1;
    pulses += int'(o_predict_valid);
    i_rst_n = 1'b1;
    pix(0, 0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b1);
    pulses += int'(o_predict_valid);
    for (int i = 0; i < 5; i++) begin
      @(posedge i_clk);
      #1;
      pulses += int'(o_predict_valid);
    end
    chk("rst.pulses", 32'(pulses), 32'd1);
    chk("rst.found", 32'(o_found), 32'd0);
    chk_box("rst.t0_after", 0, 0, 0, 0, 0);
    chk_box("rst.t1_after", 1, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
